// File: rtl/axi4_pkg.sv
// Shared AXI4 types and constants for the write-side slave and the future read side.
package axi4_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    RESP  = 2'd2
  } wr_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // A burst is illegal when it is wider than the bus, uses the reserved
  // encoding, or is a WRAP whose beat count is not 2, 4, 8 or 16.
  function automatic logic burst_illegal(input logic [2:0] size, input burst_e burst,
                                         input logic [7:0] len, input int lsb);
    logic bad;
    bad = (int'(size) > lsb) || (burst == RSVD);
    if ((burst == WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/axi_sync_fifo.sv
// Single-clock FIFO with async reset; head entry is presented combinationally on rdata.
module axi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Pointer and occupancy update; simultaneous push and pop leave the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/axi4_write_slave.sv
// AXI4 write slave: queues AW requests, walks each burst beat by beat and drives
// a registered word-addressed memory write port, returning one B per burst.
module axi4_write_slave
  import axi4_pkg::*;
#(
  parameter  int ID_W      = 10,
  parameter  int ADDR_W    = 32,
  parameter  int DATA_W    = 32,
  parameter  int AW_DEPTH  = 4,
  parameter  int MEM_WORDS = 1024,
  localparam int STRB_W    = DATA_W / 8,
  localparam int LSB       = $clog2(STRB_W),
  localparam int MA_W      = $clog2(MEM_WORDS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ID_W-1:0]   AWID,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [7:0]        AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWLOCK,
  input  logic [3:0]        AWCACHE,
  input  logic [2:0]        AWPROT,
  input  logic [3:0]        AWQOS,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [STRB_W-1:0] WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  output logic              mem_we,
  output logic [MA_W-1:0]   mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  output wr_state_e         dbg_state
);

  // Handshakes: a transfer happens on a rising edge where VALID and READY are both
  // high; VALID never waits on READY, and B holds BID/BRESP stable until BREADY.

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    burst_e            burst;
  } aw_req_t;

  localparam int REQ_W = $bits(aw_req_t);

  aw_req_t           aw_req, aw_head;
  logic [REQ_W-1:0]  fifo_rdata;
  logic              fifo_full, fifo_empty, aw_push, aw_pop, rst_done_q;

  wr_state_e         state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d, bid_q, bid_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_nxt, inc, bound, word;
  logic [7:0]        len_q, len_d, cnt_q, cnt_d;
  logic [2:0]        size_q, size_d;
  burst_e            burst_q, burst_d;
  logic              err_q, err_d, illegal_q, illegal_d;
  logic              wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              mem_we_q, mem_we_d;
  logic [MA_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
  logic              w_hs, last_beat, oor;
  logic              unused_ok;

  assign unused_ok = ^{AWLOCK, AWCACHE, AWPROT, AWQOS};

  // Pack the AW fields into a queue entry.
  always_comb begin
    aw_req       = '0;
    aw_req.id    = AWID;
    aw_req.addr  = AWADDR;
    aw_req.len   = AWLEN;
    aw_req.size  = AWSIZE;
    aw_req.burst = burst_e'(AWBURST);
  end

  assign AWREADY = rst_done_q && !fifo_full;
  assign aw_push = AWVALID && AWREADY;
  assign aw_pop  = (state_q == IDLE) && !fifo_empty;
  assign aw_head = aw_req_t'(fifo_rdata);

  axi_sync_fifo #(.WIDTH(REQ_W), .DEPTH(AW_DEPTH)) u_aw_fifo (
    .clock (clock),
    .reset (reset),
    .push  (aw_push),
    .wdata (aw_req),
    .pop   (aw_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Holds AWREADY low until the first edge after reset release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rst_done_q <= 1'b0;
    else       rst_done_q <= 1'b1;
  end

  // Next beat address for the active burst, all in ADDR_W bits.
  always_comb begin
    inc   = ADDR_W'(1) << size_q;
    bound = (ADDR_W'(len_q) + ADDR_W'(1)) * inc;
    word  = addr_q >> LSB;
    oor   = (word >= ADDR_W'(MEM_WORDS));
    case (burst_q)
      INCR:    addr_nxt = (addr_q & ~(inc - ADDR_W'(1))) + inc;
      WRAP:    addr_nxt = (addr_q & ~(bound - ADDR_W'(1))) |
                          ((addr_q + inc) & (bound - ADDR_W'(1)));
      default: addr_nxt = addr_q;
    endcase
  end

  assign w_hs      = WVALID && wready_q;
  assign last_beat = (cnt_q == len_q);

  // Burst FSM next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    illegal_d   = illegal_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          id_d      = aw_head.id;
          addr_d    = aw_head.addr;
          len_d     = aw_head.len;
          size_d    = aw_head.size;
          burst_d   = aw_head.burst;
          cnt_d     = 8'd0;
          illegal_d = burst_illegal(aw_head.size, aw_head.burst, aw_head.len, LSB);
          err_d     = illegal_d;
          wready_d  = 1'b1;
          state_d   = BURST;
        end
      end
      BURST: begin
        if (w_hs) begin
          cnt_d       = cnt_q + 8'd1;
          addr_d      = addr_nxt;
          mem_addr_d  = word[MA_W-1:0];
          mem_wdata_d = WDATA;
          mem_wstrb_d = WSTRB;
          mem_we_d    = (WSTRB != '0) && !illegal_q && !oor;
          err_d       = err_q || (WLAST != last_beat) || oor;
          if (last_beat) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bid_d    = id_q;
            bresp_d  = err_d ? RESP_SLVERR : RESP_OKAY;
            state_d  = RESP;
          end
        end
      end
      RESP: begin
        if (BREADY) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, burst context and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= FIXED;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      illegal_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      illegal_q   <= illegal_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bid_q       <= bid_d;
      bresp_q     <= bresp_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  assign WREADY    = wready_q;
  assign BVALID    = bvalid_q;
  assign BID       = bid_q;
  assign BRESP     = bresp_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_axi4_write_slave.sv
// Directed bench for axi4_write_slave with queue-based scoreboard for memory writes and B responses.
module tb_axi4_write_slave;
  import axi4_pkg::*;

  localparam int ID_W = 10, ADDR_W = 32, DATA_W = 32, STRB_W = 4, MA_W = 10;
  localparam int MW = MA_W + DATA_W + STRB_W;
  localparam int BW = ID_W + 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [ID_W-1:0]   AWID;
  logic [ADDR_W-1:0] AWADDR;
  logic [7:0]        AWLEN;
  logic [2:0]        AWSIZE;
  logic [1:0]        AWBURST;
  logic              AWLOCK, AWVALID, AWREADY;
  logic [3:0]        AWCACHE, AWQOS;
  logic [2:0]        AWPROT;
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              WLAST, WVALID, WREADY;
  logic [ID_W-1:0]   BID;
  logic [1:0]        BRESP;
  logic              BVALID, BREADY;
  logic              mem_we;
  logic [MA_W-1:0]   mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  wr_state_e         dbg_state;

  axi4_write_slave dut (
    .clock(clock), .reset(reset),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWQOS(AWQOS),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [MW-1:0] exp_q[$];
  logic [BW-1:0] exp_b_q[$];
  logic [MW-1:0] em;
  logic [BW-1:0] eb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every memory write and every B handshake is popped against the queues.
  always @(negedge clock) begin
    if (!reset) begin
      if (mem_we) begin
        if (exp_q.size() == 0) chk("unexpected mem_we", mem_we, 1'b0);
        else begin
          em = exp_q.pop_front();
          chk("mem_addr",  mem_addr,  em[MW-1 -: MA_W]);
          chk("mem_wdata", mem_wdata, em[STRB_W +: DATA_W]);
          chk("mem_wstrb", mem_wstrb, em[STRB_W-1:0]);
        end
      end
      if (BVALID && BREADY) begin
        if (exp_b_q.size() == 0) chk("unexpected bvalid", BVALID, 1'b0);
        else begin
          eb = exp_b_q.pop_front();
          chk("bid",   BID,   eb[BW-1:2]);
          chk("bresp", BRESP, eb[1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_aw(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                         input logic exp_acc, input logic [1:0] exp_resp);
    logic acc;
    @(posedge clock); #1;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst;
    AWVALID = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 12 && !acc; c++) begin
      @(negedge clock);
      if (AWREADY) acc = 1'b1;
    end
    if (acc) begin
      @(posedge clock); #1;
    end
    AWVALID = 1'b0;
    chk("aw accepted", acc, exp_acc);
    if (acc) exp_b_q.push_back({id, exp_resp});
  endtask

  task automatic send_w(input logic [DATA_W-1:0] data, input logic [STRB_W-1:0] strb,
                        input logic last, input logic exp_we, input logic [MA_W-1:0] exp_addr);
    logic acc;
    @(posedge clock); #1;
    WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 40 && !acc; c++) begin
      @(negedge clock);
      if (WREADY) acc = 1'b1;
    end
    if (acc) begin
      @(posedge clock); #1;
    end
    WVALID = 1'b0;
    chk("w accepted", acc, 1'b1);
    if (acc && exp_we) exp_q.push_back({exp_addr, data, strb});
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 100 && (exp_q.size() != 0 || exp_b_q.size() != 0); c++)
      @(posedge clock);
    chk(name, 64'(exp_q.size() + exp_b_q.size()), 64'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " awready"},   AWREADY,   1'b0);
    chk({tag, " wready"},    WREADY,    1'b0);
    chk({tag, " bvalid"},    BVALID,    1'b0);
    chk({tag, " bresp"},     BRESP,     2'b00);
    chk({tag, " bid"},       BID,       '0);
    chk({tag, " mem_we"},    mem_we,    1'b0);
    chk({tag, " mem_addr"},  mem_addr,  '0);
    chk({tag, " mem_wdata"}, mem_wdata, '0);
    chk({tag, " mem_wstrb"}, mem_wstrb, '0);
    chk({tag, " state"},     dbg_state, IDLE);
  endtask

  // ---------------- stimulus ----------------
  logic seen;
  initial begin
    reset = 1'b1;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0;
    AWLOCK = 1'b0; AWCACHE = '0; AWPROT = '0; AWQOS = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b1;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_outputs_zero("reset");
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("awready before first edge", AWREADY, 1'b0);
    @(negedge clock);
    chk("awready after release", AWREADY, 1'b1);

    // INCR 0x100 LEN3 SIZE2, with WREADY latency and BVALID timing
    send_aw(10'd5, 32'h100, 8'd3, 3'd2, INCR, 1'b1, RESP_OKAY);
    @(negedge clock); chk("wready at t+1", WREADY, 1'b0);
    @(negedge clock); chk("wready at t+2", WREADY, 1'b1);
    send_w(32'h1111_0000, 4'hF, 1'b0, 1'b1, 10'h040);
    send_w(32'h2222_0001, 4'hF, 1'b0, 1'b1, 10'h041);
    send_w(32'h3333_0002, 4'hF, 1'b0, 1'b1, 10'h042);
    send_w(32'h4444_0003, 4'hF, 1'b1, 1'b1, 10'h043);
    @(negedge clock); chk("bvalid after last beat", BVALID, 1'b1);
    drain("incr drained");

    // WRAP 0x108 LEN3 SIZE2
    send_aw(10'd2, 32'h108, 8'd3, 3'd2, WRAP, 1'b1, RESP_OKAY);
    send_w(32'hA0, 4'hF, 1'b0, 1'b1, 10'h042);
    send_w(32'hA1, 4'hF, 1'b0, 1'b1, 10'h043);
    send_w(32'hA2, 4'hF, 1'b0, 1'b1, 10'h040);
    send_w(32'hA3, 4'hF, 1'b1, 1'b1, 10'h041);
    drain("wrap drained");

    // FIXED 0x20 LEN2, zero strobe beat and partial strobe
    send_aw(10'd3, 32'h20, 8'd2, 3'd2, FIXED, 1'b1, RESP_OKAY);
    send_w(32'hB0, 4'hF, 1'b0, 1'b1, 10'h008);
    send_w(32'hB1, 4'h0, 1'b0, 1'b0, 10'h008);
    send_w(32'hB2, 4'h3, 1'b1, 1'b1, 10'h008);
    drain("fixed drained");

    // INCR LEN3 with early WLAST: all written, SLVERR
    send_aw(10'd4, 32'h200, 8'd3, 3'd2, INCR, 1'b1, RESP_SLVERR);
    send_w(32'hC0, 4'hF, 1'b0, 1'b1, 10'h080);
    send_w(32'hC1, 4'hF, 1'b1, 1'b1, 10'h081);
    send_w(32'hC2, 4'hF, 1'b0, 1'b1, 10'h082);
    send_w(32'hC3, 4'hF, 1'b0, 1'b1, 10'h083);
    drain("wlast drained");

    // WRAP LEN2 (illegal length) and WRAP SIZE3 (too wide): no writes, SLVERR
    send_aw(10'd6, 32'h0, 8'd2, 3'd2, WRAP, 1'b1, RESP_SLVERR);
    for (int i = 0; i < 3; i++) send_w(32'hD0 + i, 4'hF, (i == 2), 1'b0, '0);
    send_aw(10'd8, 32'h0, 8'd3, 3'd3, WRAP, 1'b1, RESP_SLVERR);
    for (int i = 0; i < 4; i++) send_w(32'hE0 + i, 4'hF, (i == 3), 1'b0, '0);
    drain("illegal drained");

    // Range: word 1023 written, 0x1000 suppressed
    send_aw(10'd9, 32'hFFC, 8'd1, 3'd2, INCR, 1'b1, RESP_SLVERR);
    send_w(32'hF0, 4'hF, 1'b0, 1'b1, 10'h3FF);
    send_w(32'hF1, 4'hF, 1'b1, 1'b0, '0);
    drain("range drained");

    // Queue fill with BREADY low: 5 accepted, 6th refused
    @(posedge clock); #1 BREADY = 1'b0;
    for (int i = 1; i <= 5; i++)
      send_aw(ID_W'(i), 32'h300 + 32'(4 * (i - 1)), 8'd0, 3'd2, INCR, 1'b1, RESP_OKAY);
    send_aw(10'd6, 32'h314, 8'd0, 3'd2, INCR, 1'b0, RESP_OKAY);
    @(negedge clock); chk("awready when full", AWREADY, 1'b0);
    send_w(32'h900, 4'hF, 1'b1, 1'b1, 10'h0C0);
    repeat (3) @(negedge clock);
    chk("bvalid held", BVALID, 1'b1);
    chk("wready stalled in resp", WREADY, 1'b0);
    chk("awready still full", AWREADY, 1'b0);
    @(posedge clock); #1 BREADY = 1'b1;
    for (int i = 1; i < 5; i++)
      send_w(32'h900 + 32'(i), 4'hF, 1'b1, 1'b1, MA_W'(10'h0C0 + i));
    drain("queue drained");

    // Reset mid-burst: nothing further issued
    send_aw(10'd7, 32'h400, 8'd3, 3'd2, INCR, 1'b1, RESP_OKAY);
    send_w(32'h70, 4'hF, 1'b0, 1'b1, 10'h100);
    send_w(32'h71, 4'hF, 1'b0, 1'b1, 10'h101);
    @(negedge clock);
    @(posedge clock); #1 reset = 1'b1;
    void'(exp_b_q.pop_back());
    @(negedge clock);
    chk_outputs_zero("mid reset");
    @(posedge clock); #1 reset = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clock);
      seen = seen | BVALID | mem_we;
    end
    chk("no activity after reset", seen, 1'b0);
    chk("idle after reset", dbg_state, IDLE);

    // Recovery burst
    send_aw(10'd10, 32'h40, 8'd0, 3'd2, INCR, 1'b1, RESP_OKAY);
    send_w(32'h55, 4'hF, 1'b1, 1'b1, 10'h010);
    drain("final drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
